// File: rtl/pong_match_ctrl.sv
// Match sequencer for a 2/4-player pong game: menu, timed serve, rally, point
// display, pause and game-over, with per-player saturating scores and win-by logic.
module pong_match_ctrl #(
  parameter int NUM_PLAYERS     = 2,
  parameter int SCORE_W         = 4,
  parameter int WIN_SCORE       = 7,
  parameter int WIN_BY          = 2,
  parameter int SERVE_DELAY_CYC = 25175000,
  parameter int POINT_DELAY_CYC = 12587500
) (
  input  logic                           clk_0,
  input  logic                           rst,
  input  logic                           start_trigger,
  input  logic                           pause_req,
  input  logic [1:0]                     mode_choice,
  input  logic                           hit_valid,
  input  logic [1:0]                     hit_player,
  input  logic                           miss_valid,
  input  logic [1:0]                     miss_player,
  output logic [2:0]                     state_out,
  output logic                           ball_enable,
  output logic                           ball_launch,
  output logic [1:0]                     serve_player,
  output logic                           sq_shown,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [1:0]                     winner,
  output logic                           game_over,
  output logic                           game_startup
);

  typedef enum logic [2:0] {
    MENU   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    POINT  = 3'd3,
    PAUSED = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam int TMR_MAX = (SERVE_DELAY_CYC > POINT_DELAY_CYC) ? SERVE_DELAY_CYC : POINT_DELAY_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]   SERVE_LAST = TMR_W'(SERVE_DELAY_CYC - 1);
  localparam logic [TMR_W-1:0]   POINT_LAST = TMR_W'(POINT_DELAY_CYC - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_t             state_q, state_d, saved_q;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic               four_mode_q;
  logic [1:0]         last_hitter_q;
  logic               lh_valid_q;
  logic [1:0]         serve_q;
  logic [1:0]         winner_q;
  logic               win_pending_q;
  logic               launch_q;

  logic               miss_ok, hit_ok, award;
  logic [1:0]         scorer;
  logic [SCORE_W-1:0] cur_score, new_score;
  logic               lead_ok, win_d;
  int                 active_cnt;

  // Indices 2 and 3 only exist once the 4-player mode has been latched.
  assign miss_ok = miss_valid && (four_mode_q || !miss_player[1]);
  assign hit_ok  = hit_valid  && (four_mode_q || !hit_player[1]);
  assign award   = (state_q == PLAY) && miss_ok;

  always_comb begin
    active_cnt = four_mode_q ? 4 : 2;
    scorer     = miss_player ^ 2'd1;
    if (lh_valid_q && (last_hitter_q != miss_player))
      scorer = last_hitter_q;
    cur_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (scorer == 2'(i)) cur_score = score_q[i];
    new_score = (cur_score == SCORE_MAX) ? cur_score : cur_score + SCORE_W'(1);
    lead_ok = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if ((i < active_cnt) && (scorer != 2'(i)) &&
          (int'(new_score) < int'(score_q[i]) + WIN_BY))
        lead_ok = 1'b0;
    win_d = (new_score == SCORE_MAX) || ((int'(new_score) >= WIN_SCORE) && lead_ok);
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns state_d/timer_d and no latch is inferred.
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      MENU: begin
        if (start_trigger) begin
          state_d = SERVE;
          timer_d = '0;
        end
      end
      SERVE: begin
        // The count holds at its last value so a pause there still launches on resume.
        if (timer_q != SERVE_LAST) timer_d = timer_q + TMR_W'(1);
        if (pause_req)                  state_d = PAUSED;
        else if (timer_q == SERVE_LAST) state_d = PLAY;
      end
      PLAY: begin
        if (award) begin
          state_d = POINT;
          timer_d = '0;
        end else if (pause_req) begin
          state_d = PAUSED;
        end
      end
      POINT: begin
        if (timer_q == POINT_LAST) begin
          state_d = win_pending_q ? OVER : SERVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      PAUSED: begin
        if (pause_req) state_d = saved_q;
      end
      OVER: begin
        if (start_trigger) state_d = MENU;
      end
      default: begin
        state_d = MENU;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_0) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= MENU;
      saved_q  <= SERVE;
      timer_q  <= '0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      launch_q <= (state_q == SERVE) && (state_d == PLAY);
      if ((state_q == SERVE || state_q == PLAY) && state_d == PAUSED)
        saved_q <= state_q;
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      // NOTE: scores are a handful of flops, not a RAM, so they can and must be cleared here.
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      four_mode_q   <= 1'b0;
      last_hitter_q <= 2'd0;
      lh_valid_q    <= 1'b0;
      serve_q       <= 2'd0;
      winner_q      <= 2'd0;
      win_pending_q <= 1'b0;
    end else if (state_q == MENU && start_trigger) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      four_mode_q   <= (NUM_PLAYERS == 4) && (mode_choice == 2'b10);
      lh_valid_q    <= 1'b0;
      serve_q       <= 2'd0;
      winner_q      <= 2'd0;
      win_pending_q <= 1'b0;
    end else if (award) begin
      for (int i = 0; i < NUM_PLAYERS; i++)
        if (scorer == 2'(i)) score_q[i] <= new_score;
      serve_q       <= miss_player;
      lh_valid_q    <= 1'b0;
      win_pending_q <= win_d;
      if (win_d) winner_q <= scorer;
    end else if (state_q == PLAY && hit_ok) begin
      last_hitter_q <= hit_player;
      lh_valid_q    <= 1'b1;
    end
  end

  always_comb begin
    scores = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      scores[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  assign state_out    = state_q;
  assign ball_enable  = (state_q == PLAY);
  assign ball_launch  = launch_q;
  assign serve_player = serve_q;
  assign sq_shown     = (state_q != POINT) && (state_q != MENU);
  assign winner       = winner_q;
  assign game_over    = (state_q == OVER);
  assign game_startup = (state_q == MENU);

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with short delays: serve timing, deuce,
// 4-player attribution, pause/resume, event collision and mid-match reset.
module tb_pong_match_ctrl;

  logic        clk_0 = 1'b0;
  logic        rst, start_trigger, pause_req, hit_valid, miss_valid;
  logic [1:0]  mode_choice, hit_player, miss_player;
  logic [2:0]  state_out;
  logic        ball_enable, ball_launch, sq_shown, game_over, game_startup;
  logic [1:0]  serve_player, winner;
  logic [15:0] scores;

  int n_vec = 0;
  int n_err = 0;

  pong_match_ctrl #(
    .NUM_PLAYERS(4), .SCORE_W(4), .WIN_SCORE(3), .WIN_BY(2),
    .SERVE_DELAY_CYC(4), .POINT_DELAY_CYC(3)
  ) u_dut (
    .clk_0(clk_0), .rst(rst), .start_trigger(start_trigger), .pause_req(pause_req),
    .mode_choice(mode_choice), .hit_valid(hit_valid), .hit_player(hit_player),
    .miss_valid(miss_valid), .miss_player(miss_player), .state_out(state_out),
    .ball_enable(ball_enable), .ball_launch(ball_launch), .serve_player(serve_player),
    .sq_shown(sq_shown), .scores(scores), .winner(winner), .game_over(game_over),
    .game_startup(game_startup)
  );

  always #5 clk_0 = ~clk_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic start_match(input logic [1:0] mode);
    mode_choice   = mode;
    start_trigger = 1'b1;
    tick();
    start_trigger = 1'b0;
    check("start_state", state_out, 3'd1);
    check("start_scores", scores, 16'h0000);
  endtask

  // From PLAY: optional hit, then a miss; follows POINT back into PLAY or OVER.
  task automatic do_point(input string tag, input logic hv, input logic [1:0] hp,
                          input logic [1:0] mp, input logic [15:0] exp_scores,
                          input logic exp_over);
    if (hv) begin
      hit_valid = 1'b1; hit_player = hp;
      tick();
      hit_valid = 1'b0;
    end
    miss_valid = 1'b1; miss_player = mp;
    tick();
    miss_valid = 1'b0;
    check({tag, "_scores"}, scores, exp_scores);
    check({tag, "_point"}, state_out, 3'd3);
    check({tag, "_serve_pl"}, serve_player, mp);
    check({tag, "_hidden"}, {sq_shown, ball_enable}, 2'b00);
    ticks(2);
    check({tag, "_point_hold"}, state_out, 3'd3);
    tick();
    if (exp_over) begin
      check({tag, "_over"}, state_out, 3'd5);
    end else begin
      check({tag, "_reserve"}, state_out, 3'd1);
      ticks(4);
      check({tag, "_replay"}, state_out, 3'd2);
    end
  endtask

  initial begin
    rst = 1'b1; start_trigger = 1'b0; pause_req = 1'b0; mode_choice = 2'b00;
    hit_valid = 1'b0; hit_player = 2'd0; miss_valid = 1'b0; miss_player = 2'd0;
    ticks(2);
    rst = 1'b0;
    check("rst_state", state_out, 3'd0);
    check("rst_scores", scores, 16'h0000);
    check("rst_flags", {game_startup, game_over, ball_enable, ball_launch, sq_shown}, 5'b10000);
    check("rst_serve_win", {serve_player, winner}, 4'h0);

    // 2-player match: serve timing, ignored index, deuce and win.
    start_match(2'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("serve_wait", {state_out, ball_launch}, {3'd1, 1'b0});
    end
    tick();
    check("launch_cycle", {state_out, ball_launch, ball_enable}, {3'd2, 1'b1, 1'b1});
    tick();
    check("launch_once", {state_out, ball_launch}, {3'd2, 1'b0});
    miss_valid = 1'b1; miss_player = 2'd2;
    tick();
    miss_valid = 1'b0;
    check("ignore_idx2", {state_out, scores}, {3'd2, 16'h0000});

    do_point("p1", 1'b0, 2'd0, 2'd1, 16'h0001, 1'b0);
    do_point("p2", 1'b1, 2'd1, 2'd0, 16'h0011, 1'b0);
    do_point("p3", 1'b1, 2'd0, 2'd0, 16'h0021, 1'b0);
    do_point("p4", 1'b0, 2'd0, 2'd1, 16'h0022, 1'b0);
    do_point("deuce", 1'b0, 2'd0, 2'd1, 16'h0023, 1'b0);
    do_point("win", 1'b0, 2'd0, 2'd1, 16'h0024, 1'b1);
    check("over_flags", {game_over, winner, sq_shown}, {1'b1, 2'd0, 1'b1});
    start_trigger = 1'b1;
    tick();
    start_trigger = 1'b0;
    check("over_to_menu", {state_out, game_startup}, {3'd0, 1'b1});
    check("menu_hold_scores", scores, 16'h0024);
    miss_valid = 1'b1; miss_player = 2'd1;
    tick();
    miss_valid = 1'b0;
    check("menu_ignore_miss", {state_out, scores}, {3'd0, 16'h0024});

    // 4-player match with a pause during the serve.
    start_match(2'b10);
    ticks(2);
    pause_req = 1'b1;
    tick();
    pause_req = 1'b0;
    check("paused", {state_out, sq_shown, ball_enable}, {3'd4, 1'b1, 1'b0});
    ticks(9);
    check("paused_hold", {state_out, ball_launch}, {3'd4, 1'b0});
    pause_req = 1'b1;
    tick();
    pause_req = 1'b0;
    check("resume", {state_out, ball_launch}, {3'd1, 1'b0});
    tick();
    check("resume_launch", {state_out, ball_launch}, {3'd2, 1'b1});

    do_point("hit2_miss0", 1'b1, 2'd2, 2'd0, 16'h0100, 1'b0);
    do_point("hit2_miss2", 1'b1, 2'd2, 2'd2, 16'h1100, 1'b0);

    hit_valid = 1'b1; hit_player = 2'd2;
    tick();
    miss_valid = 1'b1; miss_player = 2'd0; hit_player = 2'd3; pause_req = 1'b1;
    tick();
    miss_valid = 1'b0; hit_valid = 1'b0; pause_req = 1'b0;
    check("collide_scores", scores, 16'h1200);
    check("collide_state", state_out, 3'd3);
    ticks(3);
    check("collide_no_pause", state_out, 3'd1);

    // Mid-play reset at 2-1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_match(2'b00);
    ticks(4);
    do_point("r1", 1'b0, 2'd0, 2'd1, 16'h0001, 1'b0);
    do_point("r2", 1'b0, 2'd0, 2'd1, 16'h0002, 1'b0);
    do_point("r3", 1'b0, 2'd0, 2'd0, 16'h0012, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", state_out, 3'd0);
    check("midrst_scores", scores, 16'h0000);
    check("midrst_flags", {game_startup, ball_enable, serve_player}, {1'b1, 1'b0, 2'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
